cpu_alu: RTL and testbench

- 16-bit integer ALU of the team CPU datapath.
- Sits between the register-file read ports (arg1, arg2) and the writeback mux and PSR.
- Performs one of eight operations selected by a 3-bit opcode.
- Registers both the 16-bit result and a 5-bit flag vector used to update the processor status register.

---
 rtl/cpu_alu.sv | 103 ++++++++++
 tb/tb_cpu_alu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_alu.sv
// 16-bit datapath ALU: eight operations, result and {N,Z,F,L,C} flags
// registered with one cycle of latency.
module cpu_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] arg1,
  input  logic [WIDTH-1:0] arg2,
  input  logic [2:0]       aluop,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       PSRwrite
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_MULT = 3'd6;
  localparam logic [2:0] OP_CMP  = 3'd7;

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [2*WIDTH-1:0] prod;
  logic               add_ovf;
  logic               sub_ovf;
  logic               borrow;

  logic [WIDTH-1:0]   result_next;
  logic               n_next;
  logic               z_next;
  logic               f_next;
  logic               l_next;
  logic               c_next;

  logic [WIDTH-1:0]   result_reg;
  logic [4:0]         flags_reg;

  // Shared adder/subtractor; the extra top bit is carry-out or borrow.
  assign sum_ext  = {1'b0, arg1} + {1'b0, arg2};
  assign diff_ext = {1'b0, arg1} - {1'b0, arg2};
  assign prod     = {{WIDTH{1'b0}}, arg1} * {{WIDTH{1'b0}}, arg2};
  assign borrow   = diff_ext[WIDTH];

  assign add_ovf = (arg1[MSB] == arg2[MSB]) && (sum_ext[MSB] != arg1[MSB]);
  assign sub_ovf = (arg1[MSB] != arg2[MSB]) && (diff_ext[MSB] != arg1[MSB]);

  always_comb begin
    result_next = '0;
    n_next      = 1'b0;
    f_next      = 1'b0;
    l_next      = 1'b0;
    c_next      = 1'b0;
    case (aluop)
      OP_ADD: begin
        result_next = sum_ext[WIDTH-1:0];
        c_next      = sum_ext[WIDTH];
        f_next      = add_ovf;
      end
      OP_SUB: begin
        result_next = diff_ext[WIDTH-1:0];
        c_next      = borrow;
        f_next      = sub_ovf;
      end
      OP_OR:   result_next = arg1 | arg2;
      OP_AND:  result_next = arg1 & arg2;
      OP_XOR:  result_next = arg1 ^ arg2;
      OP_NOT:  result_next = ~arg1;
      OP_MULT: begin
        result_next = prod[WIDTH-1:0];
        c_next      = |prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        result_next = diff_ext[WIDTH-1:0];
        l_next      = borrow;
      end
    endcase
    // Signed less-than for CMP: the difference sign corrected by overflow.
    if (aluop == OP_CMP)
      n_next = diff_ext[MSB] ^ sub_ovf;
    else
      n_next = result_next[MSB];
    z_next = (result_next == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      result_reg <= '0;
      flags_reg  <= 5'b00000;
    end else begin
      result_reg <= result_next;
      flags_reg  <= {n_next, z_next, f_next, l_next, c_next};
    end
  end

  assign result   = result_reg;
  assign PSRwrite = flags_reg;

endmodule

// File: tb/tb_cpu_alu.sv
// Scoreboard bench for cpu_alu: directed edge cases plus randomized
// operations, checked against an arithmetic reference model.
module tb_cpu_alu;

  logic        clk;
  logic        reset;
  logic [15:0] arg1;
  logic [15:0] arg2;
  logic [2:0]  aluop;
  logic [15:0] result;
  logic [4:0]  PSRwrite;

  int tests_run;
  int tests_failed;
  int issued;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  flags;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  cpu_alu #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .arg1     (arg1),
    .arg2     (arg2),
    .aluop    (aluop),
    .result   (result),
    .PSRwrite (PSRwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t e;
    int unsigned ua, ub, r;
    int sa, sb, sr;
    logic n, z, f, l, c;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    r = 0; sr = 0;
    f = 0; l = 0; c = 0;
    case (op)
      3'd0: begin
        r = ua + ub; c = (r > 65535);
        sr = sa + sb; f = (sr > 32767) || (sr < -32768);
      end
      3'd1: begin
        r = ua - ub; c = (ua < ub);
        sr = sa - sb; f = (sr > 32767) || (sr < -32768);
      end
      3'd2: r = ua | ub;
      3'd3: r = ua & ub;
      3'd4: r = ua ^ ub;
      3'd5: r = ~ua;
      3'd6: begin
        r = ua * ub; c = ((r >> 16) != 0);
      end
      default: begin
        r = ua - ub; l = (ua < ub);
      end
    endcase
    r = r & 32'h0000_FFFF;
    z = (r == 0);
    if (op == 3'd7) n = (sa < sb);
    else            n = (r >= 32768);
    e.res   = r[15:0];
    e.flags = {n, z, f, l, c};
    e.tag   = "";
    return e;
  endfunction

  // Drive one operation after an edge; its response appears after the next edge.
  task automatic issue(input logic rst_n, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_n; aluop = op; arg1 = a; arg2 = b;
    if (!rst_n) begin
      e.res = 16'h0000; e.flags = 5'b00000;
    end else begin
      e = model(op, a, b);
    end
    e.tag = tag;
    exp_q.push_back(e);
    issued++;
  endtask

  // Monitor: anything queued before an edge is the response visible after it.
  initial begin
    int pending;
    exp_t e;
    forever begin
      @(posedge clk);
      pending = exp_q.size();
      @(negedge clk);
      if (pending > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (result !== e.res || PSRwrite !== e.flags) begin
          tests_failed++;
          $display("FAIL %s: got result=%h flags=%b, expected result=%h flags=%b",
                   e.tag, result, PSRwrite, e.res, e.flags);
        end else begin
          $display("[TB] ok %s: result=%h flags=%b", e.tag, result, PSRwrite);
        end
      end
    end
  end

  function automatic logic [15:0] rand_operand();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0: v = 16'h0000;
      1: v = 16'hFFFF;
      2: v = 16'h7FFF;
      3: v = 16'h8000;
      4: v = 16'h0001;
      default: v = 16'($urandom());
    endcase
    return v;
  endfunction

  initial begin
    int budget;
    logic [15:0] a, b;
    tests_run = 0; tests_failed = 0; issued = 0;
    reset = 1'b0; aluop = 3'd0; arg1 = 16'h1234; arg2 = 16'h1111;

    issue(1'b0, 3'd0, 16'h1234, 16'h1111, "reset_0");
    issue(1'b0, 3'd0, 16'h1234, 16'h1111, "reset_1");
    issue(1'b1, 3'd0, 16'h1234, 16'h1111, "first_add");

    issue(1'b1, 3'd0, 16'hFFFF, 16'h0001, "add_wrap");
    issue(1'b1, 3'd0, 16'h7FFF, 16'h0001, "add_sovf");
    issue(1'b1, 3'd1, 16'h0003, 16'h0005, "sub_borrow");
    issue(1'b1, 3'd1, 16'h8000, 16'h0001, "sub_sovf");
    issue(1'b1, 3'd7, 16'h0003, 16'h0005, "cmp_lt");
    issue(1'b1, 3'd7, 16'h0005, 16'h0005, "cmp_eq");
    issue(1'b1, 3'd7, 16'hFFFF, 16'h0001, "cmp_neg");
    issue(1'b1, 3'd7, 16'h8000, 16'h7FFF, "cmp_sovf");
    issue(1'b1, 3'd2, 16'hF0F0, 16'h0F0F, "or");
    issue(1'b1, 3'd3, 16'hF0F0, 16'h0F0F, "and");
    issue(1'b1, 3'd4, 16'hAAAA, 16'hAAAA, "xor");
    issue(1'b1, 3'd5, 16'h00FF, 16'h1234, "not");
    issue(1'b1, 3'd6, 16'h0100, 16'h0100, "mult_ovf");
    issue(1'b1, 3'd6, 16'h0003, 16'h0007, "mult_small");
    issue(1'b0, 3'd0, 16'h4000, 16'h4000, "reset_mid");
    issue(1'b1, 3'd0, 16'h4000, 16'h4000, "after_reset");

    for (int i = 0; i < 3000; i++) begin
      a = rand_operand();
      b = rand_operand();
      issue(($urandom_range(0, 63) != 0), 3'($urandom_range(0, 7)), a, b, "random");
    end

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
    end
    if (tests_run != issued + 1) begin
      tests_failed++;
      $display("FAIL count: checked %0d responses, expected %0d", tests_run - 1, issued);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
